mux_n_reg: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered output.
- Holds an internal select register that is either loaded directly or auto-advanced in round-robin scan mode.
- Used in the multicycle datapath to pick ALU/register-file/memory operands, and to sequence several sources over consecutive cycles, with a flag on each capture.

---
 rtl/mux_n_reg_pkg.sv | 13 +
 rtl/mux_n_reg_comb.sv | 25 ++
 rtl/mux_n_reg.sv | 96 +++++++++
 tb/tb_mux_n_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux_n_reg_pkg.sv
// Shared definitions for the registered N-input selector.
// Holds mode encodings and the select-width derivation.
package mux_n_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A single input still needs a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_reg_comb.sv
// Combinational N-to-1 selector, WIDTH bits per input.
// Ports: i_in_flat (N*WIDTH), i_idx (SELW), o_data (WIDTH).
module mux_n_comb
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = sel_w(N)
) (
  input  logic [N*WIDTH-1:0] i_in_flat,
  input  logic [SELW-1:0]    i_idx,
  output logic [WIDTH-1:0]   o_data
);

  // Out-of-range index falls back to input 0.
  always_comb begin
    o_data = i_in_flat[WIDTH-1:0];
    for (int k = 0; k < N; k++) begin
      if (i_idx == SELW'(k)) begin
        o_data = i_in_flat[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-input selector with direct-load and round-robin scan.
// Ports: clk, reset, in_flat, sel, sel_load, mode, en -> out, out_valid, cur_sel, wrap, sel_err.
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = sel_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SELW-1:0]    sel,
  input  logic               sel_load,
  input  logic               mode,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [SELW-1:0]    cur_sel,
  output logic               wrap,
  output logic               sel_err
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [SELW-1:0]  r_cur_sel;
  logic             r_wrap;
  logic             r_sel_err;

  logic             w_sel_ok;
  logic             w_bypass;
  logic             w_last;
  logic [SELW-1:0]  w_idx;
  logic [SELW-1:0]  w_inc;
  logic [WIDTH-1:0] w_data;

  // A full power-of-two select space can never exceed N-1.
  generate
    if ((1 << SELW) == N) begin : g_full
      assign w_sel_ok = 1'b1;
    end else begin : g_part
      assign w_sel_ok =
        ({{(32-SELW){1'b0}}, sel} < 32'(N));
    end
  endgenerate

  assign w_bypass = sel_load & w_sel_ok;
  assign w_idx    = w_bypass ? sel : r_cur_sel;
  assign w_last   = (r_cur_sel == LAST);
  assign w_inc    = w_last ? '0 : r_cur_sel + SELW'(1);

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_comb (
    .i_in_flat (in_flat),
    .i_idx     (w_idx),
    .o_data    (w_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_cur_sel   <= '0;
      r_wrap      <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_out_valid <= en;
      r_wrap      <= 1'b0;
      r_sel_err   <= sel_load & ~w_sel_ok;
      if (en) begin
        r_out <= w_data;
      end
      // A load, valid or not, suppresses the scan advance.
      if (sel_load) begin
        if (w_sel_ok) begin
          r_cur_sel <= sel;
        end
      end else if (en && mode == MODE_SCAN) begin
        r_cur_sel <= w_inc;
        r_wrap    <= w_last;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign cur_sel   = r_cur_sel;
  assign wrap      = r_wrap;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg with N=4 and N=3 instances.
// Expected captures are queued at stimulus time and popped by monitors.
module tb_mux_n_reg;

  typedef struct packed {
    logic [15:0] d;
    logic        w;
    logic [1:0]  cs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_in = {16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA};
  logic [1:0]  a_sel = '0;
  logic        a_rst = 1'b1, a_ld = 1'b0, a_mode = 1'b0, a_en = 1'b0;
  logic [15:0] a_out;
  logic        a_vld, a_wrap, a_err;
  logic [1:0]  a_cs;

  logic [47:0] b_in = {16'h3333, 16'h2222, 16'h1111};
  logic [1:0]  b_sel = '0;
  logic        b_rst = 1'b1, b_ld = 1'b0, b_mode = 1'b0, b_en = 1'b0;
  logic [15:0] b_out;
  logic        b_vld, b_wrap, b_err;
  logic [1:0]  b_cs;

  mux_n_reg #(.WIDTH(16), .N(4)) u_a (
    .clk(clk), .reset(a_rst), .in_flat(a_in), .sel(a_sel),
    .sel_load(a_ld), .mode(a_mode), .en(a_en), .out(a_out),
    .out_valid(a_vld), .cur_sel(a_cs), .wrap(a_wrap),
    .sel_err(a_err)
  );

  mux_n_reg #(.WIDTH(16), .N(3)) u_b (
    .clk(clk), .reset(b_rst), .in_flat(b_in), .sel(b_sel),
    .sel_load(b_ld), .mode(b_mode), .en(b_en), .out(b_out),
    .out_valid(b_vld), .cur_sel(b_cs), .wrap(b_wrap),
    .sel_err(b_err)
  );

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic w,
                              input logic [1:0] cs);
    exp_t e;
    e.d = d; e.w = w; e.cs = cs;
    return e;
  endfunction

  always @(negedge clk) begin
    if (a_vld === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected", 32'(a_out), 32'hDEAD);
      else chk("a_capture", 32'({a_out, a_wrap, a_cs}), 32'(qa.pop_front()));
    end
    if (b_vld === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected", 32'(b_out), 32'hDEAD);
      else chk("b_capture", 32'({b_out, b_wrap, b_cs}), 32'(qb.pop_front()));
    end
  end

  initial begin
    // 1: reset held with en=1
    a_en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out", 32'(a_out), 32'h0);
      chk("rst_vld", 32'(a_vld), 32'h0);
      chk("rst_cs", 32'(a_cs), 32'h0);
      chk("rst_wrap", 32'(a_wrap), 32'h0);
      chk("rst_b_cs", 32'(b_cs), 32'h0);
    end
    a_rst = 1'b0; b_rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
    step();

    // 2: direct load then repeated captures
    a_ld = 1'b1; a_sel = 2'd2;
    step();
    chk("load_cs", 32'(a_cs), 32'd2);
    chk("load_err", 32'(a_err), 32'd0);
    a_ld = 1'b0; a_en = 1'b1; a_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(16'hFFFF, 1'b0, 2'd2));
      step();
    end
    a_en = 1'b0;
    step();
    chk("hold_vld", 32'(a_vld), 32'd0);
    chk("hold_out", 32'(a_out), 32'hFFFF);

    // 3: scan from 0, five captures
    a_ld = 1'b1; a_sel = 2'd0;
    step();
    a_ld = 1'b0; a_mode = 1'b1; a_en = 1'b1;
    qa.push_back(mk(16'hAAAA, 1'b0, 2'd1)); step();
    qa.push_back(mk(16'h5555, 1'b0, 2'd2)); step();
    qa.push_back(mk(16'hFFFF, 1'b0, 2'd3)); step();
    qa.push_back(mk(16'h0000, 1'b1, 2'd0)); step();
    qa.push_back(mk(16'hAAAA, 1'b0, 2'd1)); step();
    a_en = 1'b0;
    step();
    chk("scan_end_cs", 32'(a_cs), 32'd1);
    chk("scan_end_wrap", 32'(a_wrap), 32'd0);

    // 4: bypass from cur_sel=3 in scan mode
    a_ld = 1'b1; a_sel = 2'd3;
    step();
    a_sel = 2'd1; a_en = 1'b1;
    qa.push_back(mk(16'h5555, 1'b0, 2'd1));
    step();
    a_ld = 1'b0; a_en = 1'b0;
    step();
    chk("byp_cs", 32'(a_cs), 32'd1);

    // 5: N=3 instance
    b_ld = 1'b1; b_sel = 2'd3; b_mode = 1'b1;
    step();
    chk("b_err_pulse", 32'(b_err), 32'd1);
    chk("b_err_cs", 32'(b_cs), 32'd0);
    b_ld = 1'b0; b_en = 1'b1;
    qb.push_back(mk(16'h1111, 1'b0, 2'd1)); step();
    chk("b_err_clear", 32'(b_err), 32'd0);
    qb.push_back(mk(16'h2222, 1'b0, 2'd2)); step();
    qb.push_back(mk(16'h3333, 1'b1, 2'd0)); step();
    qb.push_back(mk(16'h1111, 1'b0, 2'd1)); step();
    // invalid bypass: error, capture at cur_sel, no advance
    b_ld = 1'b1; b_sel = 2'd3;
    qb.push_back(mk(16'h2222, 1'b0, 2'd1));
    step();
    chk("b_byp_err", 32'(b_err), 32'd1);
    b_ld = 1'b0; b_en = 1'b0;
    step();
    chk("b_byp_cs", 32'(b_cs), 32'd1);

    // 6: reset mid-scan
    a_ld = 1'b1; a_sel = 2'd2;
    step();
    a_ld = 1'b0; a_mode = 1'b1; a_en = 1'b1; a_rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(a_out), 32'h0);
    chk("mid_rst_cs", 32'(a_cs), 32'h0);
    chk("mid_rst_vld", 32'(a_vld), 32'h0);
    a_rst = 1'b0;
    qa.push_back(mk(16'hAAAA, 1'b0, 2'd1));
    step();
    a_en = 1'b0;
    step();
    step();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
